// File: rtl/bht_if.sv
// Branch history table bus: fetch-side read port and resolved-branch update port.
// Handshake: a read is accepted on a rising edge where bht_read_valid && bht_ready;
// bht_read_data_valid is high for exactly one cycle on the following cycle, carrying
// that read's data. An update is committed on a rising edge where
// bht_write_enable && bht_valid_in && bht_ready. There is no backpressure beyond bht_ready.
interface bht_if #(
  parameter int INDEX_WIDTH = 9
);
  logic                   bht_ready;
  logic                   bht_read_valid;
  logic [INDEX_WIDTH-1:0] bht_read_index;
  logic                   bht_read_data_valid;
  logic [7:0]             bht_read_data;
  logic [3:0]             bht_predict_taken;
  logic                   bht_write_enable;
  logic [INDEX_WIDTH-1:0] bht_write_index;
  logic [1:0]             bht_write_counter_select;
  logic                   bht_write_inc;
  logic                   bht_write_dec;
  logic                   bht_valid_in;

  modport master (
    input  bht_ready, bht_read_data_valid, bht_read_data, bht_predict_taken,
    output bht_read_valid, bht_read_index, bht_write_enable, bht_write_index,
           bht_write_counter_select, bht_write_inc, bht_write_dec, bht_valid_in
  );

  modport slave (
    output bht_ready, bht_read_data_valid, bht_read_data, bht_predict_taken,
    input  bht_read_valid, bht_read_index, bht_write_enable, bht_write_index,
           bht_write_counter_select, bht_write_inc, bht_write_dec, bht_valid_in
  );
endinterface

// File: rtl/bht.sv
// Branch history table: SETS sets of four 2-bit saturating counters, one per
// 4-byte slot of a 16-byte fetch group. Registered read port with write-through,
// read-modify-write update port, and a post-reset init sweep.
module bht #(
  parameter int         INDEX_WIDTH = 9,
  parameter int         SETS        = 512,
  parameter logic [1:0] INIT_CNT    = 2'b01
) (
  input  logic  clock,
  input  logic  reset,
  bht_if.slave  bus,
  output logic  dbg_state_o
);

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t                 state_q, state_d;
  logic [INDEX_WIDTH-1:0] init_ptr_q, init_ptr_d;
  logic                   ready;
  logic                   in_init;

  logic [7:0]             mem [SETS];

  logic                   rd_fire;
  logic                   wr_fire;
  logic [7:0]             old_set;
  logic [1:0]             old_cnt;
  logic [1:0]             new_cnt;
  logic [7:0]             new_set;
  logic [2:0]             sel_lsb;

  logic                   rd_valid_q;
  logic [7:0]             rd_data_q, rd_data_d;

  // State register and sweep pointer
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= ST_INIT;
      init_ptr_q <= '0;
    end else begin
      state_q    <= state_d;
      init_ptr_q <= init_ptr_d;
    end
  end

  // Next state: sweep every set once, then run
  always_comb begin
    state_d    = state_q;
    init_ptr_d = init_ptr_q;
    if (state_q == ST_INIT) begin
      init_ptr_d = init_ptr_q + 1'b1;
      if (init_ptr_q == INDEX_WIDTH'(SETS - 1)) begin
        state_d    = ST_RUN;
        init_ptr_d = '0;
      end
    end
  end

  // FSM outputs
  always_comb begin
    ready   = 1'b0;
    in_init = 1'b0;
    case (state_q)
      ST_INIT: in_init = 1'b1;
      ST_RUN:  ready   = 1'b1;
      default: in_init = 1'b1;
    endcase
  end

  assign bus.bht_ready = ready;
  assign dbg_state_o   = state_q;

  assign rd_fire = bus.bht_read_valid && ready;
  assign wr_fire = bus.bht_write_enable && bus.bht_valid_in && ready;
  assign sel_lsb = {bus.bht_write_counter_select, 1'b0};

  // Update datapath: saturating inc/dec of the selected counter, others kept
  always_comb begin
    old_set = mem[bus.bht_write_index];
    old_cnt = old_set[sel_lsb +: 2];
    new_cnt = old_cnt;
    if (bus.bht_write_inc && !bus.bht_write_dec && old_cnt != 2'b11) begin
      new_cnt = old_cnt + 2'b01;
    end else if (bus.bht_write_dec && !bus.bht_write_inc && old_cnt != 2'b00) begin
      new_cnt = old_cnt - 2'b01;
    end
    new_set = old_set;
    new_set[sel_lsb +: 2] = new_cnt;
  end

  // Counter array: init sweep writes, otherwise committed updates
  always_ff @(posedge clock) begin
    if (in_init && !reset) begin
      mem[init_ptr_q] <= {4{INIT_CNT}};
    end else if (wr_fire) begin
      mem[bus.bht_write_index] <= new_set;
    end
  end

  // Read data select: forward the updated set when writing the same index
  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_fire) begin
      if (wr_fire && bus.bht_write_index == bus.bht_read_index) begin
        rd_data_d = new_set;
      end else begin
        rd_data_d = mem[bus.bht_read_index];
      end
    end
  end

  // Registered read port; data holds when no request
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      rd_valid_q <= rd_fire;
      rd_data_q  <= rd_data_d;
    end
  end

  assign bus.bht_read_data_valid = rd_valid_q;
  assign bus.bht_read_data       = rd_data_q;
  assign bus.bht_predict_taken   = {rd_data_q[7], rd_data_q[5], rd_data_q[3], rd_data_q[1]};

endmodule

// File: tb/tb_bht.sv
// Testbench for bht: init sweep timing, read/update vectors, write-through and
// reset-during-sweep sequences.
module tb_bht;
  localparam int IW   = 9;
  localparam int SETS = 512;

  logic clock;
  logic reset;
  logic dbg_state;

  bht_if #(.INDEX_WIDTH(IW)) bus ();

  bht #(.INDEX_WIDTH(IW), .SETS(SETS), .INIT_CNT(2'b01)) dut (
    .clock       (clock),
    .reset       (reset),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  typedef struct {
    bit          is_rd;
    logic [8:0]  idx;
    logic [1:0]  sel;
    bit          en;
    bit          vin;
    bit          inc;
    bit          dec;
    logic [7:0]  exp;
  } vec_t;

  vec_t       vecs[$];
  logic [7:0] exp_q[$];
  int         n_checks;
  int         n_fail;

  // Clock
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] taken_of(input logic [7:0] d);
    return {d[7], d[5], d[3], d[1]};
  endfunction

  task automatic idle();
    bus.bht_read_valid           = 1'b0;
    bus.bht_read_index           = '0;
    bus.bht_write_enable         = 1'b0;
    bus.bht_write_index          = '0;
    bus.bht_write_counter_select = '0;
    bus.bht_write_inc            = 1'b0;
    bus.bht_write_dec            = 1'b0;
    bus.bht_valid_in             = 1'b0;
  endtask

  task automatic add_rd(input logic [8:0] idx, input logic [7:0] exp);
    vec_t v;
    v = '{is_rd: 1'b1, idx: idx, sel: 2'd0, en: 1'b0, vin: 1'b0, inc: 1'b0, dec: 1'b0, exp: exp};
    vecs.push_back(v);
  endtask

  task automatic add_wr(input logic [8:0] idx, input logic [1:0] sel, input bit en,
                        input bit vin, input bit inc, input bit dec);
    vec_t v;
    v = '{is_rd: 1'b0, idx: idx, sel: sel, en: en, vin: vin, inc: inc, dec: dec, exp: 8'h00};
    vecs.push_back(v);
  endtask

  // Scoreboard: every returned read is matched against the oldest expectation
  always @(negedge clock) begin
    if (!reset && bus.bht_read_data_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_read_valid", 32'd1, 32'd0);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        check("read_data", {24'd0, bus.bht_read_data}, {24'd0, e});
        check("predict_taken", {28'd0, bus.bht_predict_taken}, {28'd0, taken_of(e)});
      end
    end
  end

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 10) begin
      @(negedge clock);
      n++;
    end
    check("drain_timeout", exp_q.size(), 0);
  endtask

  // Counts cycles of bht_ready low after release; optionally pokes traffic mid-sweep
  task automatic measure_sweep(input bit poke, output int cycles, output bit saw_valid);
    cycles    = 0;
    saw_valid = 1'b0;
    while (!bus.bht_ready && cycles < 2000) begin
      if (bus.bht_read_data_valid) saw_valid = 1'b1;
      if (poke && cycles >= 20 && cycles < 24) begin
        bus.bht_read_valid           = 1'b1;
        bus.bht_read_index           = 9'd3;
        bus.bht_write_enable         = 1'b1;
        bus.bht_valid_in             = 1'b1;
        bus.bht_write_index          = 9'd3;
        bus.bht_write_counter_select = 2'd0;
        bus.bht_write_inc            = 1'b1;
      end else begin
        idle();
      end
      cycles++;
      @(negedge clock);
    end
    idle();
  endtask

  initial begin
    int  cyc;
    bit  sv;
    n_checks = 0;
    n_fail   = 0;
    idle();
    reset = 1'b1;

    // Reset state
    repeat (3) @(negedge clock);
    check("reset_ready", bus.bht_ready, 0);
    check("reset_rd_valid", bus.bht_read_data_valid, 0);
    check("reset_rd_data", bus.bht_read_data, 0);
    check("reset_taken", bus.bht_predict_taken, 0);
    check("reset_state", dbg_state, 0);

    // First sweep, with reads and a write to index 3 issued mid-sweep
    reset = 1'b0;
    measure_sweep(1'b1, cyc, sv);
    check("sweep_cycles", cyc, SETS);
    check("init_rd_valid_low", sv, 0);
    check("ready_after_sweep", bus.bht_ready, 1);

    // Vector table
    add_rd(9'd0,   8'h55);
    add_rd(9'd255, 8'h55);
    add_rd(9'd511, 8'h55);
    add_rd(9'd3,   8'h55);
    add_wr(9'd7, 2'd2, 1, 1, 1, 0);
    add_wr(9'd7, 2'd2, 1, 1, 1, 0);
    add_wr(9'd7, 2'd2, 1, 1, 1, 0);
    add_rd(9'd7,   8'h75);
    add_wr(9'd7, 2'd2, 1, 1, 1, 0);
    add_rd(9'd7,   8'h75);
    add_wr(9'd9, 2'd0, 1, 1, 0, 1);
    add_wr(9'd9, 2'd0, 1, 1, 0, 1);
    add_rd(9'd9,   8'h54);
    add_wr(9'd9, 2'd0, 1, 1, 1, 1);
    add_wr(9'd9, 2'd0, 1, 0, 1, 0);
    add_wr(9'd9, 2'd0, 0, 1, 1, 0);
    add_wr(9'd9, 2'd0, 1, 1, 0, 0);
    add_wr(9'd9, 2'd0, 1, 1, 0, 1);
    add_rd(9'd9,   8'h54);
    add_wr(9'd11, 2'd3, 1, 1, 0, 1);
    add_rd(9'd11,  8'h15);
    add_wr(9'd11, 2'd3, 1, 1, 1, 0);
    add_wr(9'd11, 2'd3, 1, 1, 1, 0);
    add_wr(9'd11, 2'd3, 1, 1, 1, 0);
    add_rd(9'd11,  8'hD5);
    add_rd(9'd10,  8'h55);
    add_wr(9'd100, 2'd0, 1, 1, 1, 0);
    add_wr(9'd100, 2'd0, 1, 1, 1, 0);
    add_rd(9'd100, 8'h57);

    for (int i = 0; i < vecs.size(); i++) begin
      idle();
      if (vecs[i].is_rd) begin
        bus.bht_read_valid = 1'b1;
        bus.bht_read_index = vecs[i].idx;
        exp_q.push_back(vecs[i].exp);
      end else begin
        bus.bht_write_enable         = vecs[i].en;
        bus.bht_valid_in             = vecs[i].vin;
        bus.bht_write_index          = vecs[i].idx;
        bus.bht_write_counter_select = vecs[i].sel;
        bus.bht_write_inc            = vecs[i].inc;
        bus.bht_write_dec            = vecs[i].dec;
      end
      @(negedge clock);
    end
    idle();
    drain();

    // Data holds when no request is made
    @(negedge clock);
    check("hold_valid_low", bus.bht_read_data_valid, 0);
    check("hold_data", bus.bht_read_data, 8'h57);

    // Same-cycle read and update of index 5: write-through
    bus.bht_read_valid           = 1'b1;
    bus.bht_read_index           = 9'd5;
    bus.bht_write_enable         = 1'b1;
    bus.bht_valid_in             = 1'b1;
    bus.bht_write_index          = 9'd5;
    bus.bht_write_counter_select = 2'd1;
    bus.bht_write_inc            = 1'b1;
    exp_q.push_back(8'h59);
    @(negedge clock);
    idle();
    drain();

    // Same-cycle read of 6 while updating 12: no forwarding across indices
    bus.bht_read_valid   = 1'b1;
    bus.bht_read_index   = 9'd6;
    bus.bht_write_enable = 1'b1;
    bus.bht_valid_in     = 1'b1;
    bus.bht_write_index  = 9'd12;
    bus.bht_write_dec    = 1'b1;
    exp_q.push_back(8'h55);
    @(negedge clock);
    idle();
    bus.bht_read_valid = 1'b1;
    bus.bht_read_index = 9'd12;
    exp_q.push_back(8'h54);
    @(negedge clock);
    idle();
    drain();

    // Reset in RUN, then again at sweep cycle 200; sweep must restart from set 0
    reset = 1'b1;
    @(negedge clock);
    check("rerun_reset_ready", bus.bht_ready, 0);
    check("rerun_reset_data", bus.bht_read_data, 0);
    reset = 1'b0;
    repeat (200) @(negedge clock);
    check("mid_sweep_not_ready", bus.bht_ready, 0);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    measure_sweep(1'b0, cyc, sv);
    check("sweep2_cycles", cyc, SETS);
    check("sweep2_rd_valid_low", sv, 0);
    bus.bht_read_valid = 1'b1;
    bus.bht_read_index = 9'd100;
    exp_q.push_back(8'h55);
    @(negedge clock);
    bus.bht_read_index = 9'd7;
    exp_q.push_back(8'h55);
    @(negedge clock);
    idle();
    drain();

    // Random reads of untouched sets after the fresh sweep
    for (int i = 0; i < 8; i++) begin
      bus.bht_read_valid = 1'b1;
      bus.bht_read_index = 9'($urandom_range(0, SETS - 1));
      exp_q.push_back(8'h55);
      @(negedge clock);
    end
    idle();
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
